// File: rtl/uart_pkg.sv
// Shared encodings, receiver states and majority-sample helpers for the parametrised UART receiver.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   // Three consecutive samples centred on the middle of a bit.
   function automatic int unsigned majFirstTick(input int unsigned oversample);
      return oversample / 2 - 1;
   endfunction

   function automatic int unsigned majMidTick(input int unsigned oversample);
      return oversample / 2;
   endfunction

   function automatic int unsigned majLastTick(input int unsigned oversample);
      return oversample / 2 + 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every baudDiv clocks (0 acts as 1), restartable.
module uart_baud_tick #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk_input,
   input  logic                 rst_input,
   input  logic                 restart,
   input  logic [DIV_WIDTH-1:0] baudDiv,
   output logic                 tick_c
);

   logic [DIV_WIDTH-1:0] divCnt;
   logic [DIV_WIDTH-1:0] lastCnt;

   assign lastCnt = (baudDiv == '0) ? '0 : baudDiv - DIV_WIDTH'(1);
   // >= keeps the counter from running away if the divisor shrinks mid-count.
   assign tick_c  = (divCnt >= lastCnt);

   always_ff @(posedge clk_input) begin
      if (rst_input) begin
         divCnt <= '0;
      end else if (restart || tick_c) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority sampling, error flags and valid/ready output.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk_input,
   input  logic                 rst_input,
   input  logic                 rx_pin,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] data_output,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 overrun_clr,
   output logic                 busy
);

   localparam int unsigned TickW   = $clog2(OVERSAMPLE);
   localparam int unsigned BitCntW = $clog2(DATA_BITS);
   localparam logic [TickW-1:0]   MajFirst = TickW'(majFirstTick(OVERSAMPLE));
   localparam logic [TickW-1:0]   MajMid   = TickW'(majMidTick(OVERSAMPLE));
   localparam logic [TickW-1:0]   MajLast  = TickW'(majLastTick(OVERSAMPLE));
   localparam logic [TickW-1:0]   BitLast  = TickW'(OVERSAMPLE - 1);
   localparam logic [BitCntW-1:0] DataLast = BitCntW'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
      $error("uart_rx_param: DATA_BITS must be 5..9");
   end
   if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : gBadOversample
      $error("uart_rx_param: OVERSAMPLE must be 8 or 16");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadFifoDepth
      $error("uart_rx_param: FIFO_DEPTH must be a power of 2, at least 2");
   end

   logic                 rxSync1, rxSync2, rxPrev, armed;
   logic [1:0]           syncFill;
   rx_state_t            state, nextState;
   logic                 tick_c;
   logic [TickW-1:0]     tickIdx;
   logic [BitCntW-1:0]   bitCnt;
   logic                 stopCnt;
   logic [1:0]           samples;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 parErrPend, frmErrPend;
   logic                 startEdge, majPoint, bitEnd, majBit, parityOn, lastStop;
   logic                 parMismatch, wordDone, wordFErr, wordPErr;

   // Synchroniser plus edge flop; armed only once the real line has been seen high.
   always_ff @(posedge clk_input) begin
      if (rst_input) begin
         rxSync1  <= 1'b1;
         rxSync2  <= 1'b1;
         rxPrev   <= 1'b1;
         syncFill <= 2'b00;
         armed    <= 1'b0;
      end else begin
         rxSync1  <= rx_pin;
         rxSync2  <= rxSync1;
         rxPrev   <= rxSync2;
         syncFill <= {syncFill[0], 1'b1};
         armed    <= armed | (syncFill[1] & rxSync2);
      end
   end

   assign startEdge = (state == IDLE) && armed && rxPrev && !rxSync2;

   uart_baud_tick #(
      .DIV_WIDTH (DIV_WIDTH)
   ) uBaudTick (
      .clk_input (clk_input),
      .rst_input (rst_input),
      .restart   (startEdge),
      .baudDiv   (baud_div),
      .tick_c    (tick_c)
   );

   assign majPoint    = tick_c && (tickIdx == MajLast);
   assign bitEnd      = tick_c && (tickIdx == BitLast);
   assign majBit      = (samples[0] & samples[1]) | (samples[0] & rxSync2) | (samples[1] & rxSync2);
   assign parityOn    = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
   assign lastStop    = (stopCnt == two_stop);
   assign parMismatch = ((^shiftReg) ^ majBit) != (parity_mode == PAR_ODD);
   assign wordFErr    = frmErrPend | ~majBit;
   assign wordPErr    = parErrPend;

   always_ff @(posedge clk_input) begin
      if (rst_input) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= nextState;
         busy  <= (nextState != IDLE);
      end
   end

   always_comb begin
      nextState = state;
      wordDone  = 1'b0;
      case (state)
         IDLE:   if (startEdge) nextState = START;
         START: begin
            if (majPoint && majBit) nextState = IDLE;
            else if (bitEnd)        nextState = DATA;
         end
         DATA:   if (bitEnd && bitCnt == DataLast) nextState = parityOn ? PARITY : STOP;
         PARITY: if (bitEnd) nextState = STOP;
         STOP: begin
            if (majPoint && lastStop) begin
               wordDone  = 1'b1;
               nextState = (wordFErr && shiftReg == '0) ? BREAK : IDLE;
            end
         end
         BREAK:  if (rxSync2) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Bit timing, sample capture and per-frame error accumulation.
   always_ff @(posedge clk_input) begin
      if (rst_input) begin
         tickIdx    <= '0;
         bitCnt     <= '0;
         stopCnt    <= 1'b0;
         samples    <= 2'b11;
         shiftReg   <= '0;
         parErrPend <= 1'b0;
         frmErrPend <= 1'b0;
      end else if (state == IDLE) begin
         tickIdx    <= '0;
         bitCnt     <= '0;
         stopCnt    <= 1'b0;
         parErrPend <= 1'b0;
         frmErrPend <= 1'b0;
      end else if (tick_c) begin
         tickIdx <= (tickIdx == BitLast) ? '0 : tickIdx + TickW'(1);
         if (tickIdx == MajFirst) samples[0] <= rxSync2;
         if (tickIdx == MajMid)   samples[1] <= rxSync2;
         if (tickIdx == MajLast) begin
            case (state)
               DATA:    shiftReg <= {majBit, shiftReg[DATA_BITS-1:1]};
               PARITY:  if (parMismatch) parErrPend <= 1'b1;
               STOP:    if (!majBit) frmErrPend <= 1'b1;
               default: ;
            endcase
         end
         if (tickIdx == BitLast) begin
            case (state)
               DATA:    bitCnt  <= bitCnt + BitCntW'(1);
               STOP:    stopCnt <= 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrExW = PtrW + 1;
   localparam int unsigned EntryW = DATA_BITS + 2;

   logic [EntryW-1:0] fifoMem [FIFO_DEPTH];
   logic [PtrW:0]     wrPtr, rdPtr;
   logic              fifoEmpty, fifoFull, fifoPop, fifoPush;

   assign fifoEmpty = (wrPtr == rdPtr);
   assign fifoFull  = (wrPtr[PtrW] != rdPtr[PtrW]) && (wrPtr[PtrW-1:0] == rdPtr[PtrW-1:0]);
   assign fifoPop   = !fifoEmpty && data_ready;
   assign fifoPush  = wordDone && (!fifoFull || fifoPop);

   assign data_valid = !fifoEmpty;
   assign {frame_err, parity_err, data_output} = fifoMem[rdPtr[PtrW-1:0]];

   always_ff @(posedge clk_input) begin
      if (rst_input) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
         wrPtr   <= '0;
         rdPtr   <= '0;
         overrun <= 1'b0;
      end else begin
         if (fifoPush) begin
            fifoMem[wrPtr[PtrW-1:0]] <= {wordFErr, wordPErr, shiftReg};
            wrPtr <= wrPtr + PtrExW'(1);
         end
         if (fifoPop) rdPtr <= rdPtr + PtrExW'(1);
         if (wordDone && !fifoPush) overrun <= 1'b1;
         else if (overrun_clr)      overrun <= 1'b0;
      end
   end
`else
   logic holdPop;

   assign holdPop = data_valid && data_ready;

   // Single holding register; a word arriving while one is still held is dropped.
   always_ff @(posedge clk_input) begin
      if (rst_input) begin
         data_output <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (wordDone && (!data_valid || holdPop)) begin
            data_output <= shiftReg;
            parity_err  <= wordPErr;
            frame_err   <= wordFErr;
            data_valid  <= 1'b1;
         end else if (holdPop) begin
            data_valid  <= 1'b0;
         end
         if (wordDone && data_valid && !holdPop) overrun <= 1'b1;
         else if (overrun_clr)                   overrun <= 1'b0;
      end
   end
`endif

endmodule
